inst_fetch: RTL

Instruction fetch stage directly upstream of the register-fetch/decode stage. Owns the program counter, issues word-aligned requests to instruction memory over a valid/ready port, buffers returned instruction words with their PCs in a small in-order queue, and presents them to decode with a valid/ready handshake. A redirect (branch/JAL target from execute) flushes queued and in-flight fetches.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/inst_queue.sv | 67 ++++++
 rtl/inst_fetch.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: reset vector, instruction
// size and the {instr, pc} entry carried from fetch to decode.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0040;
   localparam int          INSTR_BYTES  = 4;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Small synchronous FIFO with flush; used for the instruction queue and for the
// PCs of fetches still in flight. DEPTH must be a power of two.
module inst_queue
   import fetch_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     i_clk,
   input  logic                     i_resetN,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [WIDTH-1:0]         o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd;
   logic [AW-1:0]    r_wr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd];

   // A pop frees the slot a same-cycle push may need when the FIFO is full.
   assign w_pop  = i_pop && !o_empty && !i_flush;
   assign w_push = i_push && (!o_full || w_pop) && !i_flush;

   always_ff @(posedge i_clk or negedge i_resetN) begin
      if (!i_resetN) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_resetN) begin
      if (!i_resetN) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr] <= i_data;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited fetches, queues
// returned words with their PCs for decode and discards fetches made stale by a redirect.
module inst_fetch
   import fetch_pkg::*;
#(
   parameter int               DBITS    = 32,
   parameter int               IBITS    = 32,
   parameter logic [DBITS-1:0] RESET_PC = DBITS'(RESET_PC_DEF),
   parameter int               QDEPTH   = 2
) (
   input  logic             clk,
   input  logic             resetN,
   output logic             imemReqValid,
   input  logic             imemReqReady,
   output logic [DBITS-1:0] imemReqAddr,
   input  logic             imemRespValid,
   input  logic [IBITS-1:0] imemRespData,
   input  logic             redirectValid,
   input  logic [DBITS-1:0] redirectPc,
   output logic             outValid,
   input  logic             outReady,
   output logic [IBITS-1:0] outInstr,
   output logic [DBITS-1:0] outPc,
   output logic [DBITS-1:0] outPcPlus4
);

   localparam int CW = $clog2(QDEPTH) + 1;

   logic [DBITS-1:0]       r_pc;
   logic [CW-1:0]          r_drop;

   logic [CW-1:0]          w_inflight;
   logic [CW-1:0]          w_qcount;
   logic [CW:0]            w_used;
   logic [DBITS-1:0]       w_fl_head;
   logic [IBITS+DBITS-1:0] w_q_head;
   logic                   w_q_empty;
   logic                   w_accept;
   logic                   w_keep;
   logic                   w_pop;
   logic                   w_unused_q_full;
   logic                   w_unused_fl_full;
   logic                   w_unused_fl_empty;
   logic                   w_unused_pc_lsbs;

   assign w_unused_pc_lsbs = &{1'b0, redirectPc[1:0]};

   // Every outstanding fetch owns a queue slot, so responses can never overflow the queue.
   assign w_used       = {1'b0, w_inflight} + {1'b0, w_qcount};
   assign imemReqValid = resetN && !redirectValid && (w_used < (CW+1)'(QDEPTH));
   assign imemReqAddr  = r_pc;
   assign w_accept     = imemReqValid && imemReqReady;

   assign w_keep = imemRespValid && !redirectValid && (r_drop == '0);
   assign w_pop  = outValid && outReady && !redirectValid;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_pc <= {RESET_PC[DBITS-1:2], 2'b00};
      end else if (redirectValid) begin
         r_pc <= {redirectPc[DBITS-1:2], 2'b00};
      end else if (w_accept) begin
         r_pc <= r_pc + DBITS'(INSTR_BYTES);
      end
   end

   // On redirect, everything still outstanding after this cycle's response is stale.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_drop <= '0;
      end else if (redirectValid) begin
         r_drop <= w_inflight - CW'(imemRespValid);
      end else if (imemRespValid && (r_drop != '0)) begin
         r_drop <= r_drop - 1'b1;
      end
   end

   inst_queue #(
      .WIDTH (DBITS),
      .DEPTH (QDEPTH)
   ) u_inflight (
      .i_clk    (clk),
      .i_resetN (resetN),
      .i_push   (w_accept),
      .i_data   (r_pc),
      .i_pop    (imemRespValid),
      .i_flush  (1'b0),
      .o_head   (w_fl_head),
      .o_count  (w_inflight),
      .o_full   (w_unused_fl_full),
      .o_empty  (w_unused_fl_empty)
   );

   inst_queue #(
      .WIDTH (IBITS + DBITS),
      .DEPTH (QDEPTH)
   ) u_iqueue (
      .i_clk    (clk),
      .i_resetN (resetN),
      .i_push   (w_keep),
      .i_data   ({imemRespData, w_fl_head}),
      .i_pop    (w_pop),
      .i_flush  (redirectValid),
      .o_head   (w_q_head),
      .o_count  (w_qcount),
      .o_full   (w_unused_q_full),
      .o_empty  (w_q_empty)
   );

   assign outValid   = !w_q_empty;
   assign outInstr   = w_q_head[IBITS+DBITS-1:DBITS];
   assign outPc      = w_q_head[DBITS-1:0];
   assign outPcPlus4 = outPc + DBITS'(INSTR_BYTES);

endmodule
